row_col_traversal: RTL and testbench
====================================

Name: row_col_traversal

Overview:
Readout-sequencing FSM for a 640x512 ROIC focal-plane array. It walks the array row by row. For each row it selects the row, waits a settle interval, then scans the column-pair index. Columns are read in even/odd pairs on two output channels, so 320 pair addresses cover 640 columns. It sits between the system clock/reset and the row/column decoders of the pixel array, and runs free after reset.

Parameters:
NUM_ROWS, 512, rows per frame (row address 0..NUM_ROWS-1)
NUM_COLS, 320, column-pair addresses per row (0..NUM_COLS-1)
ROW_SETTLE, 4, cycles the row is held selected before the column scan starts
LINE_BLANK, 4, idle cycles after each row's scan (all rows except the last)
FRAME_BLANK, 16, idle cycles after the last row, before wrapping to row 0
ROW_W, 9, row address width
COL_W, 9, column address width

Ports:
clk  input  1  system clock; 1 MHz nominal, all logic on rising edge
rst  input  1  synchronous, active-high reset
col_enable  output  COL_W  binary column-pair address; valid only in SCAN
row_enable  output  ROW_W  binary address of the currently selected row

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset:
  - state=IDLE, row_cnt=0, col_cnt=0, timer=0.
  - row_enable=0, col_enable=0.
  - Reset mid-frame aborts immediately; no partial-row completion.
- States and transitions:
  - IDLE: first edge with rst=0 goes to SETTLE with row_cnt=0 and timer=0.
  - SETTLE: timer counts 0..ROW_SETTLE-1. At ROW_SETTLE-1 go to SCAN, col_cnt=0.
  - SCAN: col_cnt increments each cycle. At NUM_COLS-1:
    - if row_cnt<NUM_ROWS-1, go to LINE_BLANK;
    - else go to FRAME_BLANK (the last row has no line blank).
  - LINE_BLANK: LINE_BLANK cycles, then SETTLE with row_cnt+1.
  - FRAME_BLANK: FRAME_BLANK cycles, then SETTLE with row_cnt=0. Free-running; no wait for external start.
- Outputs:
  - Both outputs are a combinational decode of registered state/counters; no extra latency.
  - row_enable = row_cnt in SETTLE, SCAN and LINE_BLANK; 0 in IDLE and FRAME_BLANK.
  - col_enable = col_cnt in SCAN; 0 otherwise.
- Timing with defaults:
  - Row period = 328 cycles.
  - Frame period = 511*328 + 4 + 320 + 16 = 167948 cycles.
- Counter rules:
  - Counters never exceed their terminal value; wrap is explicit via the state transitions.
  - Unused state encodings return to IDLE.
- Parameter checks (elaboration-time assertions): ROW_SETTLE>=1, LINE_BLANK>=1, FRAME_BLANK>=1; NUM_ROWS<=2**ROW_W; NUM_COLS<=2**COL_W.

Optional Feature:
Macro ROW_COL_SYNC_OUT_EN.
- Defined: adds two outputs, registered like the other outputs.
  - line_valid (1 bit): high exactly during SCAN. This disambiguates col_enable=0 during scan from idle.
  - frame_start (1 bit): one-cycle pulse on the first SETTLE cycle of row 0.
  - Both are 0 in reset.
- Undefined: ports absent; col_enable/row_enable behaviour identical.

Decomposition:
- Package row_col_traversal_pkg holds:
  - state enum (IDLE, SETTLE, SCAN, LINE_BLANK, FRAME_BLANK);
  - default geometry constants (512, 320) and default timing constants.
- One natural sub-module, row_col_timer: a loadable down-counter with a done flag. It is shared by the SETTLE, LINE_BLANK and FRAME_BLANK states.
- Column and row counters stay in the top module.

Test Plan:
1. Hold rst=1 for 5 cycles -> row_enable=0, col_enable=0 every cycle; state IDLE.
2. Release rst at edge E0 -> row_enable=0 and col_enable=0 through SETTLE (4 cycles). col_enable=0,1,... from E0+4; col_enable=319 after E0+323; 0 again after E0+324.
3. Continue -> LINE_BLANK 4 cycles; row_enable=1 after E0+328; col_enable=0 again after E0+332; 2000 cycles cover rows 0..6 with exact 328-cycle spacing.
4. Full frame -> after row 511 scan, FRAME_BLANK 16 cycles with row_enable=0; row 0 SETTLE re-entered exactly 167948 cycles after E0.
5. Assert rst during SCAN of row 3, col 100 -> next edge outputs 0; after release, sequence restarts from row 0 with identical timing to scenario 2.
6. With ROW_COL_SYNC_OUT_EN -> frame_start pulses at E0 and E0+167948; line_valid high for exactly 320 cycles per row.

Source files
------------

// File: rtl/row_col_traversal_pkg.sv
// Shared definitions for the ROIC row/column readout sequencer.
// Holds the FSM state encoding, the default array geometry and timing, and
// a helper that sizes the shared settle/blank timer.
package row_col_traversal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SETTLE      = 3'd1,
    ST_SCAN        = 3'd2,
    ST_LINE_BLANK  = 3'd3,
    ST_FRAME_BLANK = 3'd4
  } state_e;

  // Default 640x512 array read as 320 even/odd column pairs per row.
  localparam int DEF_NUM_ROWS    = 512;
  localparam int DEF_NUM_COLS    = 320;
  localparam int DEF_ROW_SETTLE  = 4;
  localparam int DEF_LINE_BLANK  = 4;
  localparam int DEF_FRAME_BLANK = 16;
  localparam int DEF_ROW_W       = 9;
  localparam int DEF_COL_W       = 9;

  // The timer is loaded with (interval - 1), so it only has to hold
  // (longest interval - 1).
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/row_col_timer.sv
// Loadable down-counter shared by the SETTLE, LINE_BLANK and FRAME_BLANK
// intervals of the readout sequencer.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : interval length minus one
//   count    : current remaining count
//   done     : count has reached zero (last cycle of the interval)
module row_col_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/row_col_traversal.sv
// Free-running readout sequencer for a ROIC focal-plane array.
// Walks rows in order: select row, settle, scan column-pair addresses,
// line blank (frame blank after the last row), then the next row.
// Optional feature macro: ROW_COL_SYNC_OUT_EN adds line_valid/frame_start.
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset, aborts the frame at once
//   col_enable  : column-pair address, non-zero only in SCAN
//   row_enable  : selected row address, 0 in IDLE and FRAME_BLANK
//   line_valid  : (optional) high for every SCAN cycle
//   frame_start : (optional) pulse on the first SETTLE cycle of row 0
module row_col_traversal
  import row_col_traversal_pkg::*;
#(
  parameter int NUM_ROWS    = DEF_NUM_ROWS,
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int ROW_SETTLE  = DEF_ROW_SETTLE,
  parameter int LINE_BLANK  = DEF_LINE_BLANK,
  parameter int FRAME_BLANK = DEF_FRAME_BLANK,
  parameter int ROW_W       = DEF_ROW_W,
  parameter int COL_W       = DEF_COL_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [COL_W-1:0] col_enable,
  output logic [ROW_W-1:0] row_enable
`ifdef ROW_COL_SYNC_OUT_EN
  ,
  output logic             line_valid,
  output logic             frame_start
`endif
);

  if (ROW_SETTLE < 1) begin : g_bad_row_settle
    $error("ROW_SETTLE must be at least 1");
  end
  if (LINE_BLANK < 1) begin : g_bad_line_blank
    $error("LINE_BLANK must be at least 1");
  end
  if (FRAME_BLANK < 1) begin : g_bad_frame_blank
    $error("FRAME_BLANK must be at least 1");
  end
  if (NUM_ROWS > (1 << ROW_W)) begin : g_bad_rows
    $error("NUM_ROWS does not fit in ROW_W bits");
  end
  if (NUM_COLS > (1 << COL_W)) begin : g_bad_cols
    $error("NUM_COLS does not fit in COL_W bits");
  end

  localparam logic [2:0] S_IDLE        = ST_IDLE;
  localparam logic [2:0] S_SETTLE      = ST_SETTLE;
  localparam logic [2:0] S_SCAN        = ST_SCAN;
  localparam logic [2:0] S_LINE_BLANK  = ST_LINE_BLANK;
  localparam logic [2:0] S_FRAME_BLANK = ST_FRAME_BLANK;

  localparam int TMR_W = timer_width(ROW_SETTLE, LINE_BLANK, FRAME_BLANK);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(ROW_SETTLE - 1);
  localparam logic [TMR_W-1:0] LINE_LD   = TMR_W'(LINE_BLANK - 1);
  localparam logic [TMR_W-1:0] FRAME_LD  = TMR_W'(FRAME_BLANK - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(NUM_COLS - 1);

  logic [2:0]       state;
  logic [ROW_W-1:0] row_cnt;
  logic [COL_W-1:0] col_cnt;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic [TMR_W-1:0] tmr_count;
  logic             tmr_done;

  // The timer is loaded on the edge that enters each timed state, so its
  // first cycle in that state already holds (interval - 1).
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LD;
    case (state)
      S_IDLE: tmr_load = 1'b1;
      S_SCAN: begin
        if (col_cnt == COL_LAST) begin
          tmr_load = 1'b1;
          tmr_val  = (row_cnt < ROW_LAST) ? LINE_LD : FRAME_LD;
        end
      end
      S_LINE_BLANK, S_FRAME_BLANK: tmr_load = tmr_done;
      default: ;
    endcase
  end

  row_col_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_SETTLE;
          row_cnt <= '0;
          col_cnt <= '0;
        end
        S_SETTLE: begin
          if (tmr_done) begin
            state   <= S_SCAN;
            col_cnt <= '0;
          end
        end
        S_SCAN: begin
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            state   <= (row_cnt < ROW_LAST) ? S_LINE_BLANK : S_FRAME_BLANK;
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
        end
        S_LINE_BLANK: begin
          if (tmr_done) begin
            state   <= S_SETTLE;
            row_cnt <= row_cnt + ROW_W'(1);
          end
        end
        S_FRAME_BLANK: begin
          if (tmr_done) begin
            state   <= S_SETTLE;
            row_cnt <= '0;
          end
        end
        default: begin
          state   <= S_IDLE;
          row_cnt <= '0;
          col_cnt <= '0;
        end
      endcase
    end
  end

  assign row_enable = (state == S_SETTLE || state == S_SCAN || state == S_LINE_BLANK)
                      ? row_cnt : '0;
  assign col_enable = (state == S_SCAN) ? col_cnt : '0;

`ifdef ROW_COL_SYNC_OUT_EN
  assign line_valid  = (state == S_SCAN);
  // The down-counter only holds SETTLE_LD on the first SETTLE cycle.
  assign frame_start = (state == S_SETTLE) && (row_cnt == '0) && (tmr_count == SETTLE_LD);
`else
  logic unused_tmr_count;
  assign unused_tmr_count = ^tmr_count;
`endif

endmodule

// File: tb/tb_row_col_traversal.sv
// Directed bench for row_col_traversal: a default-geometry instance for
// row/column timing and reset abort, and a reduced-geometry instance
// (4 rows, 8 pairs, settle 2, line blank 3, frame blank 5 -> 54-cycle
// frame) for frame-blank and frame-wrap behaviour.
module tb_row_col_traversal;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] d_col, d_row, s_col, s_row;
`ifdef ROW_COL_SYNC_OUT_EN
  logic       d_lv, d_fs, s_lv, s_fs;
`endif

  int total = 0;
  int bad   = 0;
  int n     = 0;

  always #5 clk = ~clk;

  row_col_traversal u_dut_def (
    .clk        (clk),
    .rst        (rst),
    .col_enable (d_col),
    .row_enable (d_row)
`ifdef ROW_COL_SYNC_OUT_EN
    ,
    .line_valid  (d_lv),
    .frame_start (d_fs)
`endif
  );

  row_col_traversal #(
    .NUM_ROWS    (4),
    .NUM_COLS    (8),
    .ROW_SETTLE  (2),
    .LINE_BLANK  (3),
    .FRAME_BLANK (5)
  ) u_dut_small (
    .clk        (clk),
    .rst        (rst),
    .col_enable (s_col),
    .row_enable (s_row)
`ifdef ROW_COL_SYNC_OUT_EN
    ,
    .line_valid  (s_lv),
    .frame_start (s_fs)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge after active edge E0+target.
  task automatic goto(input int target);
    while (n < target) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_d(input int row, input int col);
    chk($sformatf("def_row@%0d", n), {23'd0, d_row}, row);
    chk($sformatf("def_col@%0d", n), {23'd0, d_col}, col);
  endtask

  task automatic chk_s(input int row, input int col);
    chk($sformatf("small_row@%0d", n), {23'd0, s_row}, row);
    chk($sformatf("small_col@%0d", n), {23'd0, s_col}, col);
  endtask

  initial begin
    // Reset held for 5 cycles: everything idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_d(0, 0);
      chk_s(0, 0);
`ifdef ROW_COL_SYNC_OUT_EN
      chk("rst_lv", {31'd0, d_lv}, 0);
      chk("rst_fs", {31'd0, d_fs}, 0);
`endif
    end

    // Release; next edge is E0.
    rst = 1'b0;
    @(negedge clk);
    n = 0;
    chk_d(0, 0);
    goto(3);   chk_d(0, 0);
    goto(4);   chk_d(0, 0);
    goto(5);   chk_d(0, 1);
    goto(104); chk_d(0, 100);
    goto(323); chk_d(0, 319);
    goto(324); chk_d(0, 0);
    goto(328); chk_d(1, 0);
    goto(332); chk_d(1, 0);
    goto(333); chk_d(1, 1);
    // Row 3, column pair 100, then abort with reset.
    goto(3*328 + 4 + 100); chk_d(3, 100);
    rst = 1'b1;
    @(negedge clk);
    chk_d(0, 0);
    chk_s(0, 0);
`ifdef ROW_COL_SYNC_OUT_EN
    chk("abort_lv", {31'd0, d_lv}, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    n = 0;

    // Restart: identical timing from row 0; small instance frame walk.
    chk_d(0, 0);
    chk_s(0, 0);
`ifdef ROW_COL_SYNC_OUT_EN
    chk("s_fs@0", {31'd0, s_fs}, 1);
    chk("d_fs@0", {31'd0, d_fs}, 1);
    chk("s_lv@0", {31'd0, s_lv}, 0);
    goto(1);  chk("s_fs@1", {31'd0, s_fs}, 0);
              chk("s_lv@1", {31'd0, s_lv}, 0);
    goto(2);  chk("s_lv@2", {31'd0, s_lv}, 1);
`endif
    goto(2);  chk_s(0, 0);
    goto(3);  chk_s(0, 1); chk_d(0, 0);
    goto(4);  chk_d(0, 0);
    goto(5);  chk_d(0, 1);
    goto(9);  chk_s(0, 7);
`ifdef ROW_COL_SYNC_OUT_EN
    chk("s_lv@9", {31'd0, s_lv}, 1);
    goto(10); chk("s_lv@10", {31'd0, s_lv}, 0);
`endif
    goto(10); chk_s(0, 0);
    goto(13); chk_s(1, 0);
`ifdef ROW_COL_SYNC_OUT_EN
    chk("s_fs@13", {31'd0, s_fs}, 0);
`endif
    goto(20); chk_s(1, 5);
    goto(35); chk_s(2, 7);
    goto(36); chk_s(2, 0);
    goto(39); chk_s(3, 0);
    goto(48); chk_s(3, 7);
    // Last row: frame blank with row_enable 0, no line blank.
    goto(49); chk_s(0, 0);
    goto(53); chk_s(0, 0);
`ifdef ROW_COL_SYNC_OUT_EN
    chk("s_lv@53", {31'd0, s_lv}, 0);
    goto(54); chk("s_fs@54", {31'd0, s_fs}, 1);
    goto(55); chk("s_fs@55", {31'd0, s_fs}, 0);
`endif
    goto(55); chk_s(0, 0);
    goto(57); chk_s(0, 1);
    goto(66); chk_s(0, 0);
    goto(67); chk_s(1, 0);

    goto(104); chk_d(0, 100);
    goto(323); chk_d(0, 319);
    goto(324); chk_d(0, 0);
    goto(328); chk_d(1, 0);
    goto(333); chk_d(1, 1);
    for (int r = 2; r <= 6; r++) begin
      goto(r*328 - 1); chk_d(r - 1, 0);
      goto(r*328);     chk_d(r, 0);
      goto(r*328 + 4 + r); chk_d(r, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
